// File: rtl/nf1_cml_arb_pkg.sv
// Shared definitions for the NF1 CML input arbiter: queue count, tuser field layout,
// per-queue source-port identifiers and the arbiter FSM state type.
package nf1_cml_arb_pkg;

  localparam int NUM_QUEUES_DEF = 5;
  localparam int Q_IDX_W        = 3;

  // tuser field layout
  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_LEN_W   = 16;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DST_LSB = 24;
  localparam int PORT_W        = 8;

  typedef logic [Q_IDX_W-1:0] q_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  // One-hot port identifiers: MAC0..3 on even bits, DMA on bit 1.
  function automatic logic [PORT_W-1:0] src_port_id(input q_idx_t q);
    case (q)
      3'd0:    return 8'h01;
      3'd1:    return 8'h04;
      3'd2:    return 8'h10;
      3'd3:    return 8'h40;
      3'd4:    return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/nf1_cml_axis_skid.sv
// Two-entry AXI-Stream register slice. Upstream ready is a flop (= skid entry empty),
// so there is no combinational path from m_tready back to the producer.
module nf1_cml_axis_skid #(
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [TUSER_WIDTH-1:0]  in_tuser,
  input  logic                    in_tlast,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic [TUSER_WIDTH-1:0]  m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready
);

  localparam int PAY_W = DATA_WIDTH + DATA_WIDTH/8 + TUSER_WIDTH + 1;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic [PAY_W-1:0] skid_pay;
  logic             out_valid;
  logic             skid_valid;
  logic             ready_r;
  logic             in_fire;
  logic             out_free;
  logic             out_load;
  logic             skid_load;
  logic             out_valid_nxt;
  logic             skid_valid_nxt;

  assign in_pay   = {in_tdata, in_tkeep, in_tuser, in_tlast};
  assign in_fire  = in_tvalid & ready_r;
  assign out_free = ~out_valid | m_tready;

  // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
  always_comb begin
    out_load       = 1'b0;
    skid_load      = 1'b0;
    out_valid_nxt  = out_valid;
    skid_valid_nxt = skid_valid;
    if (out_free) begin
      out_load       = skid_valid | in_fire;
      out_valid_nxt  = skid_valid | in_fire;
      skid_valid_nxt = 1'b0;
    end else if (in_fire) begin
      skid_load      = 1'b1;
      skid_valid_nxt = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_r    <= 1'b0;
      out_pay    <= '0;
    end else begin
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      ready_r    <= ~skid_valid_nxt;
      if (out_load) out_pay <= skid_valid ? skid_pay : in_pay;
    end
  end

  // NOTE: skid payload is not reset; skid_valid alone says whether it holds a beat.
  always_ff @(posedge clk) begin
    if (skid_load) skid_pay <= in_pay;
  end

  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = out_pay;
  assign m_tvalid  = out_valid;
  assign in_tready = ready_r;

endmodule

// File: rtl/nf1_cml_input_arbiter.sv
// Packet-granular round-robin merge of the MAC/DMA receive streams into one stream.
// Optional: define ARB_SRC_PORT_STAMP_EN to stamp the source port into tuser on first beats.
module nf1_cml_input_arbiter
  import nf1_cml_arb_pkg::*;
#(
  parameter int NUM_QUEUES  = NUM_QUEUES_DEF,
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                               axis_aclk,
  input  logic                               axis_reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_QUEUES*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_QUEUES*TUSER_WIDTH-1:0]  s_tuser,
  input  logic [NUM_QUEUES-1:0]              s_tvalid,
  input  logic [NUM_QUEUES-1:0]              s_tlast,
  output logic [NUM_QUEUES-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic [DATA_WIDTH/8-1:0]            m_tkeep,
  output logic [TUSER_WIDTH-1:0]             m_tuser,
  output logic                               m_tvalid,
  output logic                               m_tlast,
  input  logic                               m_tready,
  output logic [2:0]                         arb_cur_q,
  output logic                               arb_busy
);

  localparam int KEEP_W = DATA_WIDTH/8;

  arb_state_e state, state_nxt;
  q_idx_t     last_grant, last_grant_nxt;
  q_idx_t     cur, cur_nxt;
  q_idx_t     cur_q_nxt;
  q_idx_t     sel;
  logic       sel_found;
  q_idx_t     grant_q;
  logic       grant_any;

  logic [DATA_WIDTH-1:0]  g_data;
  logic [KEEP_W-1:0]      g_keep;
  logic [TUSER_WIDTH-1:0] g_user;
  logic [TUSER_WIDTH-1:0] st_user;
  logic                   g_last;
  logic                   g_valid;
  logic                   in_valid;
  logic                   skid_ready;
  logic                   accept;

  // Round-robin scan starting just after the last queue to finish a packet.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      int     idx;
      q_idx_t cand;
      idx = int'(last_grant) + k;
      if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
      cand = q_idx_t'(idx);
      if (!sel_found && s_tvalid[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign grant_q   = (state == PKT) ? cur : sel;
  assign grant_any = (state == PKT) | sel_found;

  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_user  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (grant_q == q_idx_t'(q)) begin
        g_data  = s_tdata[q*DATA_WIDTH +: DATA_WIDTH];
        g_keep  = s_tkeep[q*KEEP_W +: KEEP_W];
        g_user  = s_tuser[q*TUSER_WIDTH +: TUSER_WIDTH];
        g_last  = s_tlast[q];
        g_valid = s_tvalid[q];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (grant_any) s_tready[grant_q] = skid_ready;
  end

  assign in_valid = grant_any & g_valid;
  assign accept   = in_valid & skid_ready;

`ifdef ARB_SRC_PORT_STAMP_EN
  logic first_beat;
  assign first_beat = (state == IDLE);

  always_comb begin
    st_user = g_user;
    if (first_beat) st_user[TUSER_SRC_LSB +: PORT_W] = src_port_id(grant_q);
  end
`else
  assign st_user = g_user;
`endif

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_nxt        = cur;
    cur_q_nxt      = arb_cur_q;
    case (state)
      IDLE: begin
        if (accept) begin
          cur_q_nxt = sel;
          if (g_last) begin
            last_grant_nxt = sel;
          end else begin
            state_nxt = PKT;
            cur_nxt   = sel;
          end
        end
      end
      PKT: begin
        if (accept && g_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = cur;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state      <= IDLE;
      last_grant <= q_idx_t'(NUM_QUEUES - 1);
      cur        <= '0;
      arb_cur_q  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cur        <= cur_nxt;
      arb_cur_q  <= cur_q_nxt;
    end
  end

  assign arb_busy = (state == PKT);

  nf1_cml_axis_skid #(
    .DATA_WIDTH  (DATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH)
  ) u_skid (
    .clk       (axis_aclk),
    .rst       (axis_reset),
    .in_tdata  (g_data),
    .in_tkeep  (g_keep),
    .in_tuser  (st_user),
    .in_tlast  (g_last),
    .in_tvalid (in_valid),
    .in_tready (skid_ready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

endmodule
